// File: rtl/phys_reg_free_list_if.sv
// Rename/commit port bundle for phys_reg_free_list.
// master: rename + commit side (drives requests/releases/flush).
// slave : the free list itself.
interface phys_reg_free_list_if #(
    parameter int unsigned PHY_REGS    = 64,
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned ALLOC_WIDTH = 2,
    parameter int unsigned FREE_WIDTH  = 2
);
    localparam int unsigned FREE_REG  = PHY_REGS - ARCH_REGS;
    localparam int unsigned PHY_WIDTH = $clog2(PHY_REGS);
    localparam int unsigned CNT_W     = $clog2(FREE_REG) + 1;

    logic [ALLOC_WIDTH-1:0]           alloc_req;
    logic                             alloc_grant;
    logic [ALLOC_WIDTH*PHY_WIDTH-1:0] alloc_preg;
    logic [FREE_WIDTH-1:0]            free_valid;
    logic [FREE_WIDTH*PHY_WIDTH-1:0]  free_preg;
    logic                             flush;
    logic [CNT_W-1:0]                 free_count;
    logic                             err;

    modport master (
        output alloc_req, free_valid, free_preg, flush,
        input  alloc_grant, alloc_preg, free_count, err
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, flush,
        output alloc_grant, alloc_preg, free_count, err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Multi-port physical-register free list for rename.
// Circular buffer of PHY_REGS-ARCH_REGS entries with head (speculative
// allocation), retire_head (committed allocation) and tail (release) pointers.
// Pointers carry one extra wrap bit, so free_count = tail - head.
// Optional integrity checking is built when FREE_LIST_CHECK_EN is defined;
// otherwise err is tied low.
module phys_reg_free_list #(
    parameter int unsigned PHY_REGS    = 64,
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned ALLOC_WIDTH = 2,
    parameter int unsigned FREE_WIDTH  = 2
) (
    input logic                 clk,
    input logic                 rst,
    phys_reg_free_list_if.slave bus
);
    localparam int unsigned FREE_REG  = PHY_REGS - ARCH_REGS;
    localparam int unsigned PHY_WIDTH = $clog2(PHY_REGS);
    localparam int unsigned CNT_W     = $clog2(FREE_REG) + 1;
    localparam int unsigned IDX_W     = CNT_W - 1;
    // Wide enough to hold any lane popcount and count + popcount without overflow.
    localparam int unsigned SUM_W     = CNT_W + $clog2(ALLOC_WIDTH + FREE_WIDTH + 1);

    logic [PHY_WIDTH-1:0] entry [FREE_REG];
    logic [CNT_W-1:0]     head;
    logic [CNT_W-1:0]     retire_head;
    logic [CNT_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic [SUM_W-1:0]     n;
    logic [SUM_W-1:0]     m;
    logic [CNT_W-1:0]     n_ptr;
    logic [CNT_W-1:0]     m_ptr;
    logic [IDX_W-1:0]     rd_idx    [ALLOC_WIDTH];
    logic [IDX_W-1:0]     wr_idx    [FREE_WIDTH];
    logic [PHY_WIDTH-1:0] lane_preg [ALLOC_WIDTH];
    logic                 grant;

    // Allocation lanes: each requesting lane takes the next entry after the
    // lanes below it; all-or-nothing grant against the current free count.
    always_comb begin
        n              = '0;
        bus.alloc_preg = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            rd_idx[i]    = head[IDX_W-1:0] + IDX_W'(n);
            lane_preg[i] = entry[rd_idx[i]];
            bus.alloc_preg[i*PHY_WIDTH +: PHY_WIDTH] = lane_preg[i];
            n = n + SUM_W'(bus.alloc_req[i]);
        end
        n_ptr           = CNT_W'(n);
        count           = tail - head;
        grant           = (n <= SUM_W'(count)) && !bus.flush && !rst;
        bus.alloc_grant = grant;
        bus.free_count  = count;
    end

    // Release lanes: valid lanes are packed in lane order starting at tail.
    always_comb begin
        m = '0;
        for (int unsigned j = 0; j < FREE_WIDTH; j++) begin
            wr_idx[j] = tail[IDX_W-1:0] + IDX_W'(m);
            m = m + SUM_W'(bus.free_valid[j]);
        end
        m_ptr = CNT_W'(m);
    end

    // Pointer and storage update; flush rewinds head to the committed point
    // including this cycle's commits, releases are always accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < FREE_REG; k++) begin
                entry[k] <= PHY_WIDTH'(ARCH_REGS + k);
            end
            head        <= '0;
            retire_head <= '0;
            tail        <= CNT_W'(FREE_REG);
        end else begin
            for (int unsigned j = 0; j < FREE_WIDTH; j++) begin
                if (bus.free_valid[j]) begin
                    entry[wr_idx[j]] <= bus.free_preg[j*PHY_WIDTH +: PHY_WIDTH];
                end
            end
            tail        <= tail + m_ptr;
            retire_head <= retire_head + m_ptr;
            if (bus.flush) begin
                head <= retire_head + m_ptr;
            end else if (grant) begin
                head <= head + n_ptr;
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic [PHY_REGS-1:0]  is_free;
    logic [PHY_REGS-1:0]  is_free_nxt;
    logic                 err_q;
    logic                 err_set;
    logic                 pristine;
    logic [CNT_W-1:0]     live;
    logic [IDX_W-1:0]     off;
    logic [PHY_WIDTH-1:0] rel;

    // Next is-free bitmap and error detection. On flush the bitmap is rebuilt
    // from the committed window [retire_head, tail) before this cycle's
    // releases are added on top.
    always_comb begin
        is_free_nxt = is_free;
        err_set     = 1'b0;
        live        = tail - retire_head;
        off         = '0;
        rel         = '0;
        if (bus.flush) begin
            is_free_nxt = '0;
            for (int unsigned k = 0; k < FREE_REG; k++) begin
                off = IDX_W'(k) - retire_head[IDX_W-1:0];
                if ({1'b0, off} < live) begin
                    is_free_nxt[entry[k]] = 1'b1;
                end
            end
        end else if (grant) begin
            for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
                if (bus.alloc_req[i]) begin
                    if (!is_free[lane_preg[i]]) begin
                        err_set = 1'b1;
                    end
                    is_free_nxt[lane_preg[i]] = 1'b0;
                end
            end
        end
        for (int unsigned j = 0; j < FREE_WIDTH; j++) begin
            if (bus.free_valid[j]) begin
                rel = bus.free_preg[j*PHY_WIDTH +: PHY_WIDTH];
                // Catches both a stale free entry and two lanes releasing the
                // same register in one cycle.
                if (is_free_nxt[rel] || (!bus.flush && is_free[rel])) begin
                    err_set = 1'b1;
                end
                // Before any rename, architectural registers have no older
                // mapping that could legitimately be released.
                if (pristine && (rel < PHY_WIDTH'(ARCH_REGS))) begin
                    err_set = 1'b1;
                end
                is_free_nxt[rel] = 1'b1;
            end
        end
        if ((SUM_W'(count) + m) > SUM_W'(FREE_REG)) begin
            err_set = 1'b1;
        end
    end

    // Bitmap, sticky error and "nothing allocated since reset" tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < PHY_REGS; k++) begin
                is_free[k] <= (k >= ARCH_REGS);
            end
            err_q    <= 1'b0;
            pristine <= 1'b1;
        end else begin
            is_free <= is_free_nxt;
            err_q   <= err_q | err_set;
            if (grant && (n != '0)) begin
                pristine <= 1'b0;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
    localparam int unsigned PHY_REGS    = 64;
    localparam int unsigned ARCH_REGS   = 32;
    localparam int unsigned ALLOC_WIDTH = 2;
    localparam int unsigned FREE_WIDTH  = 2;

    typedef struct packed {
        logic        grant;
        logic [1:0]  chk;
        logic [11:0] preg;
        logic [5:0]  count;
        logic        err;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    phys_reg_free_list_if #(
        .PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS),
        .ALLOC_WIDTH(ALLOC_WIDTH), .FREE_WIDTH(FREE_WIDTH)
    ) bus ();

    phys_reg_free_list #(
        .PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS),
        .ALLOC_WIDTH(ALLOC_WIDTH), .FREE_WIDTH(FREE_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    sb_t         exp_q[$];
    int unsigned fq[$];
    int unsigned spec_q[$];
    int unsigned held[$];
    logic        exp_err;
    int          assertions = 0;
    int          failures   = 0;

    logic        obs_grant;
    logic [11:0] obs_preg;
    logic [5:0]  obs_count;
    logic        obs_err;

    // Reference: fq is the allocatable list in order, spec_q the allocations
    // not yet retired, held the committed mappings that may be released.
    task automatic model_reset();
        fq.delete();
        spec_q.delete();
        held.delete();
        for (int unsigned k = 0; k < 32; k++) begin
            fq.push_back(32 + k);
            held.push_back(k);
        end
        exp_err = 1'b0;
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] fv,
                        input logic [11:0] fp, input logic fl);
        sb_t         e;
        int unsigned n;
        int unsigned m;
        int unsigned r;
        n = $countones(req);
        m = $countones(fv);
        e = '0;
        e.grant = (n <= fq.size()) && !fl;
        r = 0;
        for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
                if (e.grant) begin
                    e.chk[i] = 1'b1;
                    e.preg[i*6 +: 6] = 6'(fq[r]);
                end
                r++;
            end
        end
        e.count = 6'(fq.size());
        e.err   = exp_err;
        exp_q.push_back(e);
        bus.alloc_req  = req;
        bus.free_valid = fv;
        bus.free_preg  = fp;
        bus.flush      = fl;
        @(negedge clk);
        obs_grant = bus.alloc_grant;
        obs_preg  = bus.alloc_preg;
        obs_count = bus.free_count;
        obs_err   = bus.err;
        @(posedge clk);
        for (int unsigned k = 0; k < m; k++) begin
            if (spec_q.size() > 0) void'(spec_q.pop_front());
        end
        if (fl) begin
            while (spec_q.size() > 0) fq.push_front(spec_q.pop_back());
        end else if (e.grant) begin
            for (int unsigned k = 0; k < n; k++) spec_q.push_back(fq.pop_front());
        end
        for (int j = 0; j < 2; j++) begin
            if (fv[j]) fq.push_back(32'(fp[j*6 +: 6]));
        end
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.alloc_req  = '0;
        bus.free_valid = '0;
        bus.free_preg  = '0;
        bus.flush      = 1'b0;
        exp_q.delete();
        @(negedge clk);
        assertions++;
        if (bus.alloc_grant !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant_first: got %b want 0", bus.alloc_grant);
        end
        @(posedge clk);
        @(negedge clk);
        assertions++;
        if (bus.alloc_grant !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant: got %b want 0", bus.alloc_grant);
        end
        assertions++;
        if (bus.free_count !== 6'd32) begin
            failures++;
            $display("FAIL reset_count: got %0d want 32", bus.free_count);
        end
        assertions++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b want 0", bus.err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_alloc_basic();
        sb_t e;
        step(2'b11, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_grant !== 1'b1 || obs_grant !== e.grant) begin
            failures++;
            $display("FAIL basic_grant: got %b want 1", obs_grant);
        end
        assertions++;
        if (obs_preg !== {6'd33, 6'd32} || obs_preg !== e.preg) begin
            failures++;
            $display("FAIL basic_preg: got %h want %h", obs_preg, {6'd33, 6'd32});
        end
        step(2'b00, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_count !== 6'd30 || obs_count !== e.count) begin
            failures++;
            $display("FAIL basic_count: got %0d want 30", obs_count);
        end
    endtask

    task automatic test_drain_and_refill();
        sb_t e;
        for (int c = 0; c < 16; c++) begin
            step(2'b11, 2'b00, '0, 1'b0);
            e = exp_q.pop_front();
            assertions++;
            if (obs_grant !== e.grant || obs_count !== 6'(32 - 2 * c)) begin
                failures++;
                $display("FAIL drain_cycle%0d: got grant %b count %0d want grant %b count %0d",
                         c, obs_grant, obs_count, e.grant, 32 - 2 * c);
            end
            assertions++;
            if (obs_preg !== e.preg) begin
                failures++;
                $display("FAIL drain_preg%0d: got %h want %h", c, obs_preg, e.preg);
            end
        end
        step(2'b01, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_grant !== 1'b0 || obs_count !== 6'd0) begin
            failures++;
            $display("FAIL empty_grant: got grant %b count %0d want 0 0", obs_grant, obs_count);
        end
        // Release {5,7} while asking for one: not allocatable until next cycle.
        step(2'b01, 2'b11, {6'd5, 6'd7}, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_grant !== 1'b0 || obs_count !== 6'd0 || obs_grant !== e.grant) begin
            failures++;
            $display("FAIL same_cycle_release: got grant %b count %0d want 0 0", obs_grant, obs_count);
        end
        step(2'b01, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_grant !== 1'b1 || obs_preg[5:0] !== 6'd7 || obs_preg[5:0] !== e.preg[5:0]) begin
            failures++;
            $display("FAIL refill_alloc: got grant %b preg0 %0d want 1 7", obs_grant, obs_preg[5:0]);
        end
        assertions++;
        if (obs_count !== e.count) begin
            failures++;
            $display("FAIL refill_count: got %0d want %0d", obs_count, e.count);
        end
    endtask

    task automatic test_flush();
        sb_t e;
        for (int c = 0; c < 3; c++) begin
            step(2'b11, 2'b00, '0, 1'b0);
            void'(exp_q.pop_front());
        end
        step(2'b00, 2'b11, {6'd2, 6'd1}, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_count !== e.count) begin
            failures++;
            $display("FAIL flush_precount: got %0d want %0d", obs_count, e.count);
        end
        // Flush wins over a simultaneous allocation request.
        step(2'b11, 2'b00, '0, 1'b1);
        e = exp_q.pop_front();
        assertions++;
        if (obs_grant !== 1'b0 || obs_grant !== e.grant) begin
            failures++;
            $display("FAIL flush_blocks_alloc: got %b want 0", obs_grant);
        end
        step(2'b01, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_count !== e.count || obs_count !== 6'd32) begin
            failures++;
            $display("FAIL flush_count: got %0d want %0d", obs_count, e.count);
        end
        assertions++;
        if (obs_grant !== 1'b1 || obs_preg[5:0] !== 6'd34 || obs_preg[5:0] !== e.preg[5:0]) begin
            failures++;
            $display("FAIL flush_realloc: got grant %b preg0 %0d want 1 34", obs_grant, obs_preg[5:0]);
        end
    endtask

    task automatic test_last_entry();
        sb_t e;
        for (int c = 0; c < 15; c++) begin
            step(2'b11, 2'b00, '0, 1'b0);
            void'(exp_q.pop_front());
        end
        step(2'b01, 2'b00, '0, 1'b0);
        void'(exp_q.pop_front());
        step(2'b10, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_count !== 6'd1 || obs_grant !== 1'b1 || obs_grant !== e.grant) begin
            failures++;
            $display("FAIL last_grant: got grant %b count %0d want 1 1", obs_grant, obs_count);
        end
        assertions++;
        if (obs_preg[11:6] !== 6'd63 || obs_preg[11:6] !== e.preg[11:6]) begin
            failures++;
            $display("FAIL last_lane1: got %0d want 63", obs_preg[11:6]);
        end
        step(2'b00, 2'b00, '0, 1'b0);
        e = exp_q.pop_front();
        assertions++;
        if (obs_count !== 6'd0 || obs_count !== e.count) begin
            failures++;
            $display("FAIL last_count: got %0d want 0", obs_count);
        end
    endtask

    task automatic test_double_free();
        sb_t e;
        step(2'b11, 2'b00, '0, 1'b0);
        void'(exp_q.pop_front());
        // Register 40 is still on the free list.
        step(2'b00, 2'b01, {6'd0, 6'd40}, 1'b0);
        void'(exp_q.pop_front());
`ifdef FREE_LIST_CHECK_EN
        exp_err = 1'b1;
`endif
        for (int c = 0; c < 4; c++) begin
            step(2'b00, 2'b00, '0, 1'b0);
            e = exp_q.pop_front();
            assertions++;
            if (obs_err !== e.err) begin
                failures++;
                $display("FAIL double_free_err%0d: got %b want %b", c, obs_err, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_t         e;
        logic [1:0]  req;
        logic [1:0]  fv;
        logic [11:0] fp;
        logic        fl;
        int unsigned mmax;
        int unsigned k;
        int unsigned retired[$];
        for (int c = 0; c < 400; c++) begin
            req  = 2'($urandom_range(0, 3));
            fl   = ($urandom_range(0, 15) == 0);
            mmax = (spec_q.size() < 2) ? spec_q.size() : 2;
            fv   = '0;
            fp   = '0;
            k    = 0;
            for (int j = 0; j < 2; j++) begin
                if (k < mmax && $urandom_range(0, 1) == 1) begin
                    fv[j] = 1'b1;
                    fp[j*6 +: 6] = 6'(held.pop_front());
                    k++;
                end
            end
            retired.delete();
            for (int unsigned i = 0; i < k; i++) retired.push_back(spec_q[i]);
            step(req, fv, fp, fl);
            while (retired.size() > 0) held.push_back(retired.pop_front());
            e = exp_q.pop_front();
            assertions++;
            if (obs_grant !== e.grant || obs_count !== e.count || obs_err !== e.err) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got grant %b count %0d err %b want %b %0d %b",
                         c, obs_grant, obs_count, obs_err, e.grant, e.count, e.err);
            end
            for (int i = 0; i < 2; i++) begin
                if (e.chk[i]) begin
                    assertions++;
                    if (obs_preg[i*6 +: 6] !== e.preg[i*6 +: 6]) begin
                        failures++;
                        $display("FAIL b2b_lane%0d_cycle%0d: got %0d want %0d",
                                 i, c, obs_preg[i*6 +: 6], e.preg[i*6 +: 6]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alloc_basic();
        test_reset();
        test_drain_and_refill();
        test_reset();
        test_flush();
        test_reset();
        test_last_entry();
        test_reset();
        test_double_free();
        test_reset();
        test_back_to_back();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
